debug_reg_reader: RTL and testbench

- Debug-side reader for the DECODE-stage register-bank debug port. After the pipeline halts, it takes over the bank read port A (debug select plus debug address) and walks registers 0..N_REGS-1.
- It captures each 32-bit word and serializes it MSB byte first to the UART transmitter using a start/done byte handshake.
- It sits between the debug unit's top FSM (start/done) and the UART TX.

---
 rtl/debug_reg_reader.sv | 167 ++++++++++++++++
 tb/tb_debug_reg_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_reg_reader.sv
// rtl/debug_reg_reader.sv - register-bank debug dump, one byte at a time, to the UART TX
//
// Walks bank read port A over registers 0..N_REGS-1, captures each word and
// hands it to the UART transmitter MSB byte first over a start/done handshake.
//
// Ports:
//   i_clock                clock, rising edge
//   i_reset                asynchronous reset, active low
//   i_start                dump request, honoured only when idle
//   o_ctrl_read_debug_reg  1 = bank port A addressed by o_addr_debug_unit
//   o_addr_debug_unit      register address being read
//   i_data_reg_debug_unit  bank port A read data
//   o_tx_start             one-cycle pulse, o_tx_data valid
//   o_tx_data              byte to transmit
//   i_tx_done              UART TX finished the current byte
//   o_busy                 dump in progress
//   o_done                 one-cycle pulse after the last byte is acknowledged

module debug_reg_reader #(
  parameter int NB_DATA  = 32,
  parameter int NB_REG   = 5,
  parameter int N_REGS   = 32,
  parameter int NB_BYTE  = 8,
  parameter int READ_LAT = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_ctrl_read_debug_reg,
  output logic [NB_REG-1:0]  o_addr_debug_unit,
  input  logic [NB_DATA-1:0] i_data_reg_debug_unit,
  output logic               o_tx_start,
  output logic [NB_BYTE-1:0] o_tx_data,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BYTES   = NB_DATA / NB_BYTE;
  localparam int NB_BCNT = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int NB_LAT  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [NB_REG-1:0]  REG_LAST  = NB_REG'(N_REGS - 1);
  localparam logic [NB_BCNT-1:0] BYTE_LAST = NB_BCNT'(BYTES - 1);
  localparam logic [NB_LAT-1:0]  LAT_LAST  = NB_LAT'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NB_REG-1:0]    reg_cnt_q, reg_cnt_d;
  logic [NB_LAT-1:0]    lat_cnt_q, lat_cnt_d;
  logic [NB_BCNT-1:0]   byte_cnt_q, byte_cnt_d;
  logic [NB_DATA-1:0]   shreg_q, shreg_d;
  logic                 ctrl_d, tx_start_d, busy_d, done_d;
  logic [NB_REG-1:0]    addr_d;
  logic [NB_BYTE-1:0]   tx_data_d;
  logic [NB_DATA-1:0]   shreg_shift;

  // Next byte to send is the top of the already-shifted word, so o_tx_data
  // can be registered on the same edge the shift happens.
  assign shreg_shift = shreg_q << NB_BYTE;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q               <= S_IDLE;
      reg_cnt_q             <= '0;
      lat_cnt_q             <= '0;
      byte_cnt_q            <= '0;
      shreg_q               <= '0;
      o_ctrl_read_debug_reg <= 1'b0;
      o_addr_debug_unit     <= '0;
      o_tx_start            <= 1'b0;
      o_tx_data             <= '0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
    end else begin
      state_q               <= state_d;
      reg_cnt_q             <= reg_cnt_d;
      lat_cnt_q             <= lat_cnt_d;
      byte_cnt_q            <= byte_cnt_d;
      shreg_q               <= shreg_d;
      o_ctrl_read_debug_reg <= ctrl_d;
      o_addr_debug_unit     <= addr_d;
      o_tx_start            <= tx_start_d;
      o_tx_data             <= tx_data_d;
      o_busy                <= busy_d;
      o_done                <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so they are registered and line up
  // with the state they belong to (e.g. o_tx_start is high exactly in SEND).
  always_comb begin
    state_d    = state_q;
    reg_cnt_d  = reg_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    ctrl_d     = o_ctrl_read_debug_reg;
    addr_d     = o_addr_debug_unit;
    tx_data_d  = o_tx_data;
    busy_d     = o_busy;
    tx_start_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_LOAD;
          reg_cnt_d = '0;
          addr_d    = '0;
          ctrl_d    = 1'b1;
          busy_d    = 1'b1;
          lat_cnt_d = '0;
        end
      end
      S_LOAD: begin
        lat_cnt_d = lat_cnt_q + 1'b1;
        if (lat_cnt_q == LAT_LAST) begin
          shreg_d    = i_data_reg_debug_unit;
          byte_cnt_d = '0;
          tx_start_d = 1'b1;
          tx_data_d  = i_data_reg_debug_unit[NB_DATA-1 -: NB_BYTE];
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (byte_cnt_q < BYTE_LAST) begin
            shreg_d    = shreg_shift;
            byte_cnt_d = byte_cnt_q + 1'b1;
            tx_start_d = 1'b1;
            tx_data_d  = shreg_shift[NB_DATA-1 -: NB_BYTE];
            state_d    = S_SEND;
          end else if (reg_cnt_q < REG_LAST) begin
            reg_cnt_d = reg_cnt_q + 1'b1;
            addr_d    = reg_cnt_q + 1'b1;
            lat_cnt_d = '0;
            state_d   = S_LOAD;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            ctrl_d  = 1'b0;
            addr_d  = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_debug_reg_reader.sv
// tb/tb_debug_reg_reader.sv - directed self-checking bench for debug_reg_reader

module tb_debug_reg_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // u0: defaults, u1: READ_LAT=2, u2: N_REGS=4 / NB_REG=2
  logic        start0, ctrl0, txs0, txdone0, busy0, done0;
  logic [4:0]  addr0;
  logic [31:0] data0;
  logic [7:0]  txd0;
  logic        start1, ctrl1, txs1, txdone1, busy1, done1;
  logic [4:0]  addr1;
  logic [31:0] data1;
  logic [7:0]  txd1;
  logic        start2, ctrl2, txs2, txdone2, busy2, done2;
  logic [1:0]  addr2;
  logic [31:0] data2;
  logic [7:0]  txd2;

  logic [31:0] mem  [0:31];
  logic [31:0] mem1 [0:31];

  assign data0 = mem[int'(addr0)];
  assign data2 = mem[int'(addr2)];
  // Two-cycle bank: garbage while debug select is off, so a too-early
  // capture shows up as BAD0BAD0 or the previous register.
  always @(posedge clk) data1 <= ctrl1 ? mem1[int'(addr1)] : 32'hBAD0BAD0;

  debug_reg_reader u0 (
    .i_clock(clk), .i_reset(rst_n), .i_start(start0),
    .o_ctrl_read_debug_reg(ctrl0), .o_addr_debug_unit(addr0),
    .i_data_reg_debug_unit(data0), .o_tx_start(txs0), .o_tx_data(txd0),
    .i_tx_done(txdone0), .o_busy(busy0), .o_done(done0)
  );

  debug_reg_reader #(.READ_LAT(2)) u1 (
    .i_clock(clk), .i_reset(rst_n), .i_start(start1),
    .o_ctrl_read_debug_reg(ctrl1), .o_addr_debug_unit(addr1),
    .i_data_reg_debug_unit(data1), .o_tx_start(txs1), .o_tx_data(txd1),
    .i_tx_done(txdone1), .o_busy(busy1), .o_done(done1)
  );

  debug_reg_reader #(.N_REGS(4), .NB_REG(2)) u2 (
    .i_clock(clk), .i_reset(rst_n), .i_start(start2),
    .o_ctrl_read_debug_reg(ctrl2), .o_addr_debug_unit(addr2),
    .i_data_reg_debug_unit(data2), .o_tx_start(txs2), .o_tx_data(txd2),
    .i_tx_done(txdone2), .o_busy(busy2), .o_done(done2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] qb0[$], qb1[$], qb2[$];
  int qa0[$], qa1[$], qa2[$], qt0[$];
  int ndone0 = 0, ndone1 = 0, ndone2 = 0, done_cyc0 = 0;
  int done_addr2 = -1;
  logic done_ctrl2 = 1'b1, pre_ctrl2 = 1'b0, prev_ctrl2 = 1'b0;

  always @(negedge clk) begin
    if (txs0) begin qb0.push_back(txd0); qa0.push_back(int'(addr0)); qt0.push_back(cyc); end
    if (done0) begin ndone0++; done_cyc0 = cyc; end
    if (txs1) begin qb1.push_back(txd1); qa1.push_back(int'(addr1)); end
    if (done1) ndone1++;
    if (txs2) begin qb2.push_back(txd2); qa2.push_back(int'(addr2)); end
    if (done2) begin
      ndone2++;
      done_addr2 = int'(addr2);
      done_ctrl2 = ctrl2;
      pre_ctrl2  = prev_ctrl2;
    end
    prev_ctrl2 = ctrl2;
  end

  // UART model for u0: 0 = done 3 cycles after tx_start, 1 = done tied high,
  // 2 = as mode 0 plus a spurious done during every SEND cycle.
  logic [1:0] tx_mode = 2'd0;
  int cd0 = 0;
  initial begin
    logic pulse;
    txdone0 = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_mode == 2'd1) begin
        txdone0 = 1'b1;
      end else begin
        pulse = 1'b0;
        if (cd0 != 0) begin
          cd0--;
          if (cd0 == 0) pulse = 1'b1;
        end
        if (txs0) cd0 = 3;
        txdone0 = pulse | ((tx_mode == 2'd2) && txs0);
      end
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int b);
    logic [31:0] t;
    t = w << (8 * b);
    return t[31:24];
  endfunction

  // Byte and address errors of the u0 stream starting at base against mem.
  function automatic int stream_errs0(input int base, input int n);
    int e = 0;
    for (int k = 0; k < n; k++)
      if (qb0[base+k] !== exp_byte(mem[k/4], k % 4) || qa0[base+k] != k / 4) e++;
    return e;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done0(input int nd);
    for (int i = 0; i < 3000 && ndone0 == nd; i++) tick();
  endtask

  task automatic pulse_start0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  initial begin
    int b0, nd, n, errs, t_start;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    txdone1 = 1'b1; txdone2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      mem[i]  = 32'(32'h01010101 * i);
      mem1[i] = 32'(32'h01010101 * i);
    end
    mem[5]  = 32'hDEADBEEF;
    mem1[5] = 32'hDEADBEEF;
    mem1[0] = 32'hCAFEF00D;

    repeat (3) tick();
    check("reset_u0", {ctrl0, addr0, txs0, txd0, busy0, done0}, 0);
    check("reset_u1", {ctrl1, addr1, txs1, txd1, busy1, done1}, 0);
    check("reset_u2", {ctrl2, addr2, txs2, txd2, busy2, done2}, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Full dump, done pulsed 3 cycles after each tx_start
    b0 = qb0.size(); nd = ndone0;
    pulse_start0();
    check("busy_after_start", {busy0, ctrl0, addr0}, {2'b11, 5'd0});
    wait_done0(nd);
    repeat (5) tick();
    n = qb0.size() - b0;
    check("full_byte_count", n, 128);
    errs = stream_errs0(b0, (n > 128) ? 128 : n);
    check("full_stream_errs", errs, 0);
    if (n >= 24) check("reg5_word", {qb0[b0+20], qb0[b0+21], qb0[b0+22], qb0[b0+23]}, 32'hDEADBEEF);
    check("full_done_pulses", ndone0 - nd, 1);
    check("full_idle_after", {busy0, ctrl0, addr0}, 0);

    // tx_done tied high: spacing and total duration
    tx_mode = 2'd1;
    tick();
    b0 = qb0.size(); nd = ndone0;
    t_start = cyc;
    pulse_start0();
    wait_done0(nd);
    repeat (3) tick();
    n = qb0.size() - b0;
    check("fast_byte_count", n, 128);
    check("fast_duration", done_cyc0 - t_start + 1, 290);
    if (n >= 1) check("fast_first_latency", qt0[b0] - t_start, 2);
    errs = 0;
    for (int k = 1; k < ((n > 128) ? 128 : n); k++)
      if (qt0[b0+k] - qt0[b0+k-1] != ((k % 4 == 0) ? 3 : 2)) errs++;
    check("fast_spacing_errs", errs, 0);

    // Spurious done during SEND, spurious start during WAIT of reg 3
    tx_mode = 2'd2;
    tick(); tick();
    b0 = qb0.size(); nd = ndone0;
    pulse_start0();
    for (int i = 0; i < 500 && qb0.size() - b0 < 13; i++) tick();
    tick();
    check("spur_in_reg3_wait", {txs0, addr0}, {1'b0, 5'd3});
    pulse_start0();
    wait_done0(nd);
    repeat (20) tick();
    n = qb0.size() - b0;
    check("spur_byte_count", n, 128);
    check("spur_stream_errs", stream_errs0(b0, (n > 128) ? 128 : n), 0);
    check("spur_done_pulses", ndone0 - nd, 1);
    check("spur_no_restart", busy0, 0);

    // Asynchronous reset at reg 10 byte 2, between clock edges
    tx_mode = 2'd0;
    tick(); tick(); tick(); tick();
    b0 = qb0.size();
    pulse_start0();
    for (int i = 0; i < 1000 && qb0.size() - b0 < 43; i++) tick();
    check("abort_point", {txs0, addr0, txd0}, {1'b1, 5'd10, 8'h0A});
    #1 rst_n = 1'b0;
    #1 check("abort_outputs_zero", {ctrl0, addr0, txs0, txd0, busy0, done0}, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    n = qb0.size();
    repeat (10) tick();
    check("abort_no_more_bytes", qb0.size() - n, 0);
    check("abort_idle", busy0, 0);
    mem[0] = 32'h11223344;
    b0 = qb0.size();
    pulse_start0();
    for (int i = 0; i < 100 && qb0.size() - b0 < 4; i++) tick();
    check("restart_count", qb0.size() - b0 >= 4, 1);
    if (qb0.size() - b0 >= 4) begin
      check("restart_word", {qb0[b0], qb0[b0+1], qb0[b0+2], qb0[b0+3]}, 32'h11223344);
      check("restart_addr", qa0[b0], 0);
    end
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem[0] = 32'h0;
    tick();

    // READ_LAT = 2
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 0; i < 2000 && ndone1 == 0; i++) tick();
    n = qb1.size();
    check("lat2_byte_count", n, 128);
    if (n >= 8) begin
      check("lat2_reg0_word", {qb1[0], qb1[1], qb1[2], qb1[3]}, 32'hCAFEF00D);
      check("lat2_reg0_addr", {qa1[0] == 0, qa1[1] == 0, qa1[2] == 0, qa1[3] == 0}, 4'hF);
      check("lat2_reg1_word", {qb1[4], qb1[5], qb1[6], qb1[7]}, 32'h01010101);
    end
    check("lat2_done", ndone1, 1);

    // N_REGS = 4
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int i = 0; i < 500 && ndone2 == 0; i++) tick();
    tick();
    n = qb2.size();
    check("n4_byte_count", n, 16);
    errs = 0;
    for (int k = 0; k < ((n > 16) ? 16 : n); k++)
      if (qb2[k] !== exp_byte(mem[k/4], k % 4) || qa2[k] != k / 4) errs++;
    check("n4_stream_errs", errs, 0);
    check("n4_done_addr", done_addr2, 0);
    check("n4_ctrl_fall", {pre_ctrl2, done_ctrl2}, 2'b10);
    check("n4_idle_after", {busy2, ctrl2}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
